// File: rtl/debounce_pkg.sv
// Shared definitions for the button conditioning stage and the counter it feeds.
// Holds the debounce FSM encoding and the default timing parameters.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } state_t;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/debounce_pulse_sync_chain.sv
// Multi-flop synchroniser bringing the raw asynchronous line into the clk domain.
// Only the last stage is visible; earlier stages give metastability time to settle.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic s
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign s = chain[STAGES-1];

endmodule

// File: rtl/debounce_pulse.sv
// Debouncer producing a clean level and one-cycle edge pulses from a bouncy input.
// rise_pulse serves as the count enable of the downstream counter.
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             s;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    logic             rise_next;
    logic             fall_next;
    logic             busy_next;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .s     (s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            btn_level  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            btn_level  <= level_next;
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
            busy       <= busy_next;
        end
    end

    // A candidate level must be seen on D+1 consecutive samples; any bounce drops back to idle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = btn_level;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        unique case (state)
            IDLE_LOW: begin
                if (s) begin
                    state_next = WAIT_HIGH;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                    level_next = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_next = WAIT_LOW;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                    level_next = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
                level_next = 1'b0;
            end
        endcase
        busy_next = (state_next == WAIT_HIGH) || (state_next == WAIT_LOW);
    end

endmodule

// File: tb/tb_debounce_pulse.sv
// Self-checking bench for debounce_pulse: directed scenarios plus random bouncing,
// compared every cycle against a run-length reference model of the debouncer.
module tb_debounce_pulse;

    localparam int SYNC = 2;
    localparam int D    = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_in;
    logic btn_level;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;

    // Reference model: delay line for the synchroniser, then a run-length rule on its output.
    logic pipe[$];
    logic mLevel;
    int   mRun;
    logic mRise;
    logic mFall;

    int riseCount, fallCount, busyCount;
    int lastRiseEdge, lastFallEdge;

    debounce_pulse #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, actual, expected, cycleCount);
        end
    endtask

    task automatic modelStep(input logic r, input logic b);
        logic s;
        if (!r) begin
            pipe.delete();
            for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);
            mLevel = 1'b0;
            mRun   = 0;
            mRise  = 1'b0;
            mFall  = 1'b0;
        end else begin
            s     = pipe[SYNC-1];
            mRise = 1'b0;
            mFall = 1'b0;
            if (s != mLevel) begin
                mRun++;
                if (mRun == D + 1) begin
                    mLevel = s;
                    mRise  = s;
                    mFall  = !s;
                    mRun   = 0;
                end
            end else begin
                mRun = 0;
            end
            pipe.push_front(b);
            void'(pipe.pop_back());
        end
    endtask

    task automatic applyStimulus(input logic r, input logic b);
        rst_n  = r;
        btn_in = b;
        modelStep(r, b);
        @(posedge clk);
        cycleCount++;
        #1;
        checkOutput("btn_level", int'(btn_level), int'(mLevel));
        checkOutput("rise_pulse", int'(rise_pulse), int'(mRise));
        checkOutput("fall_pulse", int'(fall_pulse), int'(mFall));
        checkOutput("busy", int'(busy), (mRun != 0) ? 1 : 0);
        checkOutput("pulse_excl", int'(rise_pulse & fall_pulse), 0);
        if (rise_pulse === 1'b1) begin
            riseCount++;
            lastRiseEdge = cycleCount;
        end
        if (fall_pulse === 1'b1) begin
            fallCount++;
            lastFallEdge = cycleCount;
        end
        if (busy === 1'b1) busyCount++;
    endtask

    task automatic runFor(input logic b, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, b);
    endtask

    task automatic clearStats();
        riseCount    = 0;
        fallCount    = 0;
        busyCount    = 0;
        lastRiseEdge = -1;
        lastFallEdge = -1;
    endtask

    initial begin
        int base;
        rst_n  = 1'b0;
        btn_in = 1'b0;
        pipe.delete();
        for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);
        mLevel = 1'b0;
        mRun   = 0;
        mRise  = 1'b0;
        mFall  = 1'b0;
        clearStats();

        // 1: reset with button held high, then release
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t1_reset_level", int'(btn_level), 0);
        checkOutput("t1_reset_busy", int'(busy), 0);
        clearStats();
        base = cycleCount;
        runFor(1'b1, 12);
        checkOutput("t1_rise_count", riseCount, 1);
        checkOutput("t1_rise_edge", lastRiseEdge - base, 7);

        // 2: clean press from a settled low level
        runFor(1'b0, 10);
        clearStats();
        base = cycleCount;
        runFor(1'b1, 10);
        checkOutput("t2_rise_count", riseCount, 1);
        checkOutput("t2_rise_edge", lastRiseEdge - base, 7);
        checkOutput("t2_busy_cycles", busyCount, 4);
        checkOutput("t2_level", int'(btn_level), 1);

        // 4: release
        clearStats();
        base = cycleCount;
        runFor(1'b0, 8);
        checkOutput("t4_fall_count", fallCount, 1);
        checkOutput("t4_fall_edge", lastFallEdge - base, 7);
        checkOutput("t4_level", int'(btn_level), 0);

        // 3: glitch of 4 cycles rejected, 5 cycles accepted
        runFor(1'b0, 4);
        clearStats();
        runFor(1'b1, 4);
        runFor(1'b0, 10);
        checkOutput("t3_glitch_rise", riseCount, 0);
        checkOutput("t3_glitch_busy", (busyCount > 0) ? 1 : 0, 1);
        checkOutput("t3_glitch_level", int'(btn_level), 0);
        clearStats();
        base = cycleCount;
        runFor(1'b1, 5);
        runFor(1'b0, 3);
        checkOutput("t3_accept_rise", riseCount, 1);
        checkOutput("t3_accept_edge", lastRiseEdge - base, 7);
        runFor(1'b0, 10);

        // 5: bounce every 2 cycles for 20 cycles, then settle high
        applyStimulus(1'b0, 1'b0);
        runFor(1'b0, 3);
        clearStats();
        for (int k = 0; k < 10; k++) runFor(((k % 2) == 0) ? 1'b1 : 1'b0, 2);
        base = cycleCount;
        runFor(1'b1, 15);
        checkOutput("t5_rise_count", riseCount, 1);
        checkOutput("t5_rise_edge", lastRiseEdge - base, 7);

        // 6: reset while qualifying a press with cnt=3
        runFor(1'b0, 12);
        clearStats();
        runFor(1'b1, 5);
        checkOutput("t6_busy_before", int'(busy), 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t6_reset_busy", int'(busy), 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t6_reset_rise", riseCount, 0);
        base = cycleCount;
        runFor(1'b1, 10);
        checkOutput("t6_rise_count", riseCount, 1);
        checkOutput("t6_rise_edge", lastRiseEdge - base, 7);

        // Random bouncing with occasional resets
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 14) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 2)); j++)
                    applyStimulus(1'b0, 1'($urandom_range(0, 1)));
            end else begin
                runFor(1'($urandom_range(0, 1)), int'($urandom_range(1, 10)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
